// File: rtl/lsu_writeback_collector.sv
// Per-warp load writeback collector: gathers out-of-order per-lane LSU responses
// for one outstanding load and issues a single masked register-file write.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module lsu_writeback_collector #(
  parameter int THREADS_PER_WARP = 4,
  parameter int DATA_WIDTH       = `DATA_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       issue_valid,
  output logic                                       issue_ready,
  input  logic [THREADS_PER_WARP-1:0]                issue_thread_mask,
  input  logic [4:0]                                 issue_rd_address,
  input  logic                                       issue_write_enable,
  input  logic [THREADS_PER_WARP-1:0]                rsp_valid,
  input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] rsp_data,
  output logic                                       wb_valid,
  input  logic                                       wb_ready,
  output logic [4:0]                                 wb_rd_address,
  output logic [THREADS_PER_WARP-1:0]                wb_thread_mask,
  output logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] wb_data,
  output logic                                       done,
  output logic                                       unexpected_rsp,
  output logic                                       busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITEBACK} state_t;

  state_t                                     state;
  logic [THREADS_PER_WARP-1:0]                pending;
  logic [THREADS_PER_WARP-1:0]                pending_next;
  logic [THREADS_PER_WARP-1:0]                stray;
  logic [THREADS_PER_WARP-1:0]                mask_q;
  logic [4:0]                                 rd_q;
  logic                                       we_q;
  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] buffer;

  // Registers 0 and 29..31 are not writable by loads.
  function automatic logic rd_writable(input logic [4:0] rd);
    return (rd != 5'd0) && (rd < 5'd29);
  endfunction

  always_comb begin
    pending_next = pending & ~rsp_valid;
    stray        = (state == COLLECT) ? (rsp_valid & ~pending) : rsp_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pending        <= '0;
      mask_q         <= '0;
      rd_q           <= '0;
      we_q           <= 1'b0;
      buffer         <= '0;
      done           <= 1'b0;
      unexpected_rsp <= 1'b0;
    end else begin
      done           <= 1'b0;
      unexpected_rsp <= |stray;
      case (state)
        IDLE: begin
          if (issue_valid) begin
            mask_q  <= issue_thread_mask;
            rd_q    <= issue_rd_address;
            we_q    <= issue_write_enable;
            pending <= issue_thread_mask;
            if (issue_thread_mask == '0) done  <= 1'b1;
            else                         state <= COLLECT;
          end
        end
        COLLECT: begin
          for (int i = 0; i < THREADS_PER_WARP; i++) begin
            if (rsp_valid[i] && pending[i]) buffer[i] <= rsp_data[i];
          end
          pending <= pending_next;
          if (pending_next == '0) begin
            if (we_q && rd_writable(rd_q)) begin
              state <= WRITEBACK;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (wb_ready) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lanes outside the mask never expose stale buffer contents.
  always_comb begin
    for (int i = 0; i < THREADS_PER_WARP; i++) begin
      wb_data[i] = mask_q[i] ? buffer[i] : '0;
    end
  end

  assign issue_ready    = (state == IDLE);
  assign busy           = (state != IDLE);
  assign wb_valid       = (state == WRITEBACK);
  assign wb_rd_address  = rd_q;
  assign wb_thread_mask = mask_q;

endmodule

// File: tb/tb_lsu_writeback_collector.sv
// Directed bench for lsu_writeback_collector with a writeback scoreboard queue.
module tb_lsu_writeback_collector;

  localparam int T = 4;
  localparam int D = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [T-1:0]         issue_thread_mask;
  logic [4:0]           issue_rd_address;
  logic                 issue_write_enable;
  logic [T-1:0]         rsp_valid;
  logic [T-1:0][D-1:0]  rsp_data;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [4:0]           wb_rd_address;
  logic [T-1:0]         wb_thread_mask;
  logic [T-1:0][D-1:0]  wb_data;
  logic                 done;
  logic                 unexpected_rsp;
  logic                 busy;

  lsu_writeback_collector #(.THREADS_PER_WARP(T), .DATA_WIDTH(D)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_thread_mask(issue_thread_mask), .issue_rd_address(issue_rd_address),
    .issue_write_enable(issue_write_enable),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_address(wb_rd_address),
    .wb_thread_mask(wb_thread_mask), .wb_data(wb_data),
    .done(done), .unexpected_rsp(unexpected_rsp), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]          rd;
    logic [T-1:0]        mask;
    logic [T-1:0][D-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  checks    = 0;
  int  errors    = 0;
  int  done_cnt  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every accepted write is popped and compared.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          chk("wb_extra", 1, 0);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          chk("wb_rd", wb_rd_address, e.rd);
          chk("wb_mask", wb_thread_mask, e.mask);
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [T-1:0] m, input logic [4:0] rd, input logic we);
    issue_valid        = 1'b1;
    issue_thread_mask  = m;
    issue_rd_address   = rd;
    issue_write_enable = we;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic rsp(input logic [T-1:0] lanes, input logic [T-1:0][D-1:0] d);
    rsp_valid = lanes;
    rsp_data  = d;
    tick();
    rsp_valid = '0;
  endtask

  task automatic push(input logic [4:0] rd, input logic [T-1:0] m, input logic [T-1:0][D-1:0] d);
    wb_t e;
    e.rd = rd; e.mask = m; e.data = d;
    exp_q.push_back(e);
  endtask

  logic [T-1:0][D-1:0] all_lanes;
  logic [T-1:0][D-1:0] one_lane;

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0; issue_thread_mask = '0; issue_rd_address = '0;
    issue_write_enable = 1'b0; rsp_valid = '0; rsp_data = '0; wb_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    @(negedge clk);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd_address, 0);
    chk("rst_wb_mask", wb_thread_mask, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_done", done, 0);
    chk("rst_unexp", unexpected_rsp, 0);
    tick();

    // Full mask, out-of-order responses.
    push(5'd5, 4'b1111, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    issue(4'b1111, 5'd5, 1'b1);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_issue_ready", issue_ready, 0);
    tick();
    one_lane = '0; one_lane[2] = 32'hA2; rsp(4'b0100, one_lane);
    one_lane = '0; one_lane[0] = 32'hA0; rsp(4'b0001, one_lane);
    one_lane = '0; one_lane[3] = 32'hA3; rsp(4'b1000, one_lane);
    @(negedge clk);
    chk("t1_wb_early", wb_valid, 0);
    tick();
    one_lane = '0; one_lane[1] = 32'hA1; rsp(4'b0010, one_lane);
    @(negedge clk);
    chk("t1_wb_valid", wb_valid, 1);
    tick();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_wb_drop", wb_valid, 0);
    chk("t1_issue_ready", issue_ready, 1);
    tick();

    // Sparse mask, all lanes respond together.
    push(5'd9, 4'b0101, {32'h0, 32'hB2, 32'h0, 32'hB0});
    issue(4'b0101, 5'd9, 1'b1);
    all_lanes = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    rsp(4'b1111, all_lanes);
    @(negedge clk);
    chk("t2_unexp", unexpected_rsp, 1);
    chk("t2_wb_valid", wb_valid, 1);
    tick();
    @(negedge clk);
    chk("t2_unexp_pulse", unexpected_rsp, 0);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    @(negedge clk);
    chk("t2_done", done, 1);
    tick();

    // Read-only destination and drain-only load: no write.
    issue(4'b0011, 5'd30, 1'b1);
    rsp(4'b0011, {32'h0, 32'h0, 32'hC1, 32'hC0});
    @(negedge clk);
    chk("t3_no_wb", wb_valid, 0);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    tick();
    issue(4'b0011, 5'd7, 1'b0);
    rsp(4'b0011, {32'h0, 32'h0, 32'hC3, 32'hC2});
    @(negedge clk);
    chk("t3b_no_wb", wb_valid, 0);
    chk("t3b_done", done, 1);
    tick();

    // Writeback stall with a duplicate response.
    push(5'd3, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hC0});
    issue(4'b0001, 5'd3, 1'b1);
    one_lane = '0; one_lane[0] = 32'hC0; rsp(4'b0001, one_lane);
    for (int k = 0; k < 10; k++) begin
      rsp_valid = (k == 3) ? 4'b0001 : 4'b0000;
      rsp_data  = '0; rsp_data[0] = 32'hD0;
      @(negedge clk);
      chk("t4_wb_valid", wb_valid, 1);
      chk("t4_wb_data", wb_data, {32'h0, 32'h0, 32'h0, 32'hC0});
      chk("t4_wb_rd", wb_rd_address, 5'd3);
      if (k == 4) chk("t4_unexp", unexpected_rsp, 1);
      tick();
    end
    rsp_valid = '0;
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    @(negedge clk);
    chk("t4_done", done, 1);
    tick();

    // Null issue followed immediately by a real one.
    issue_valid = 1'b1; issue_thread_mask = 4'b0000; issue_rd_address = 5'd4;
    issue_write_enable = 1'b1;
    tick();
    issue_thread_mask = 4'b1000; issue_rd_address = 5'd12;
    @(negedge clk);
    chk("t5_null_done", done, 1);
    chk("t5_null_busy", busy, 0);
    chk("t5_null_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("t5_b2b_busy", busy, 1);
    tick();
    push(5'd12, 4'b1000, {32'hE3, 32'h0, 32'h0, 32'h0});
    one_lane = '0; one_lane[3] = 32'hE3; rsp(4'b1000, one_lane);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    @(negedge clk);
    chk("t5_done", done, 1);
    tick();

    // Reset mid-transaction.
    issue(4'b1111, 5'd20, 1'b1);
    one_lane = '0; one_lane[0] = 32'hF0; rsp(4'b0001, one_lane);
    one_lane = '0; one_lane[1] = 32'hF1; rsp(4'b0010, one_lane);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_wb_valid", wb_valid, 0);
    chk("t6_done", done, 0);
    chk("t6_ready", issue_ready, 1);
    tick();
    rsp(4'b1100, {32'hF3, 32'hF2, 32'h0, 32'h0});
    @(negedge clk);
    chk("t6_unexp", unexpected_rsp, 1);
    chk("t6_no_wb", wb_valid, 0);
    tick();
    push(5'd1, 4'b0110, {32'h0, 32'h62, 32'h61, 32'h0});
    issue(4'b0110, 5'd1, 1'b1);
    rsp(4'b0110, {32'h0, 32'h62, 32'h61, 32'h0});
    @(negedge clk);
    chk("t6_wb_valid", wb_valid, 1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    @(negedge clk);
    chk("t6_fresh_done", done, 1);
    tick(); tick();

    chk("sb_empty", exp_q.size(), 0);
    chk("done_count", done_cnt, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
